// File: rtl/seletor_minimo_ativo_pkg.sv
// Shared definitions for the active-minimum selector: FSM encoding and
// width helpers derived from the node count and lanes per beat.
package seletor_minimo_ativo_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        VARRER   = 2'd1,
        CONCLUIR = 2'd2
    } estado_t;

    // Bits needed to address n nodes (never below one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Scan beats needed to cover n nodes with l lanes per beat.
    function automatic int num_beats(input int n, input int l);
        return (n + l - 1) / l;
    endfunction

    // Beat counter width for b beats (never below one bit).
    function automatic int beat_width(input int b);
        return (b > 1) ? $clog2(b) : 1;
    endfunction

endpackage

// File: rtl/arvore_minimo.sv
// Combinational LANES-input minimum/argmin with active masking.
// Equal criteria resolve to the lowest lane.
module arvore_minimo
    import seletor_minimo_ativo_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int CRITERIO_WIDTH = 5,
    parameter int IDX_W          = 3
) (
    input  logic [LANES-1:0]                i_ativo,
    input  logic [LANES*CRITERIO_WIDTH-1:0] i_criterio,
    input  logic [LANES*IDX_W-1:0]          i_indice,
    output logic                            o_valido,
    output logic [CRITERIO_WIDTH-1:0]       o_criterio,
    output logic [IDX_W-1:0]                o_indice
);

    logic                      w_valido;
    logic [CRITERIO_WIDTH-1:0] w_criterio;
    logic [IDX_W-1:0]          w_indice;

    // Walk the lanes in ascending order; only a strictly smaller criterion
    // displaces the current best, so the lowest lane wins ties.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_valido   = 1'b0;
        w_criterio = '1;
        w_indice   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i_ativo[i] && (!w_valido || (i_criterio[i*CRITERIO_WIDTH +: CRITERIO_WIDTH] < w_criterio))) begin
                w_valido   = 1'b1;
                w_criterio = i_criterio[i*CRITERIO_WIDTH +: CRITERIO_WIDTH];
                w_indice   = i_indice[i*IDX_W +: IDX_W];
            end
        end
    end

    assign o_valido   = w_valido;
    assign o_criterio = w_criterio;
    assign o_indice   = w_indice;

endmodule

// File: rtl/seletor_minimo_ativo.sv
// Multi-beat scanner that selects the active node with the smallest
// criterion from a snapshot taken at the start request.
module seletor_minimo_ativo
    import seletor_minimo_ativo_pkg::*;
#(
    parameter int NUM_NA         = 8,
    parameter int CRITERIO_WIDTH = 5,
    parameter int LANES          = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             aa_atualizar_in,
    input  logic [NUM_NA-1:0]                na_ativo_in,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
    output logic                             ca_ocupado_o,
    output logic                             ca_pronto_o,
    output logic                             ca_valido_o,
    output logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_out,
    output logic [idx_width(NUM_NA)-1:0]     ca_indice_out
);

    localparam int IDX_W     = idx_width(NUM_NA);
    localparam int NUM_BEATS = num_beats(NUM_NA, LANES);
    localparam int BEAT_W    = beat_width(NUM_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    estado_t                         r_estado;
    estado_t                         w_prox_estado;
    logic [NUM_NA-1:0]               r_snap_ativo;
    logic [NUM_NA*CRITERIO_WIDTH-1:0] r_snap_criterio;
    logic [BEAT_W-1:0]               r_beat;
    logic                            r_acc_achou;
    logic [CRITERIO_WIDTH-1:0]       r_acc_criterio;
    logic [IDX_W-1:0]                r_acc_indice;
    logic                            r_pronto;
    logic                            r_valido;
    logic [CRITERIO_WIDTH-1:0]       r_criterio_out;
    logic [IDX_W-1:0]                r_indice_out;

    logic                            w_ultimo_beat;
    logic                            w_ocupado;
    logic                            w_publicar;

    // Snapshot rearranged as [beat][lane]; lanes past the last node are inactive.
    logic                            w_ativo_grid    [NUM_BEATS][LANES];
    logic [CRITERIO_WIDTH-1:0]       w_criterio_grid [NUM_BEATS][LANES];
    logic [IDX_W-1:0]                w_indice_grid   [NUM_BEATS][LANES];

    logic [LANES-1:0]                w_lane_ativo;
    logic [LANES*CRITERIO_WIDTH-1:0] w_lane_criterio;
    logic [LANES*IDX_W-1:0]          w_lane_indice;

    logic                            w_arv_valido;
    logic [CRITERIO_WIDTH-1:0]       w_arv_criterio;
    logic [IDX_W-1:0]                w_arv_indice;

    for (genvar gb = 0; gb < NUM_BEATS; gb++) begin : g_beat
        for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
            localparam int N = gb * LANES + gl;
            if (N < NUM_NA) begin : g_real
                assign w_ativo_grid[gb][gl]    = r_snap_ativo[N];
                assign w_criterio_grid[gb][gl] = r_snap_criterio[N*CRITERIO_WIDTH +: CRITERIO_WIDTH];
                assign w_indice_grid[gb][gl]   = IDX_W'(N);
            end else begin : g_pad
                assign w_ativo_grid[gb][gl]    = 1'b0;
                assign w_criterio_grid[gb][gl] = '1;
                assign w_indice_grid[gb][gl]   = '0;
            end
        end
    end

    for (genvar gl = 0; gl < LANES; gl++) begin : g_sel
        assign w_lane_ativo[gl]                                     = w_ativo_grid[r_beat][gl];
        assign w_lane_criterio[gl*CRITERIO_WIDTH +: CRITERIO_WIDTH] = w_criterio_grid[r_beat][gl];
        assign w_lane_indice[gl*IDX_W +: IDX_W]                     = w_indice_grid[r_beat][gl];
    end

    arvore_minimo #(
        .LANES          (LANES),
        .CRITERIO_WIDTH (CRITERIO_WIDTH),
        .IDX_W          (IDX_W)
    ) u_arvore (
        .i_ativo    (w_lane_ativo),
        .i_criterio (w_lane_criterio),
        .i_indice   (w_lane_indice),
        .o_valido   (w_arv_valido),
        .o_criterio (w_arv_criterio),
        .o_indice   (w_arv_indice)
    );

    assign w_ultimo_beat = (r_beat == LAST_BEAT);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_estado <= OCIOSO;
        else     r_estado <= w_prox_estado;
    end

    // FSM next state: a start request restarts the scan from any state.
    always_comb begin
        w_prox_estado = r_estado;
        unique case (r_estado)
            OCIOSO:   if (aa_atualizar_in) w_prox_estado = VARRER;
            VARRER:   if (aa_atualizar_in) w_prox_estado = VARRER;
                      else if (w_ultimo_beat) w_prox_estado = CONCLUIR;
            CONCLUIR: w_prox_estado = aa_atualizar_in ? VARRER : OCIOSO;
            default:  w_prox_estado = OCIOSO;
        endcase
    end

    // FSM outputs: busy while scanning; publish on leaving CONCLUIR unless aborted.
    always_comb begin
        w_ocupado  = (r_estado == VARRER);
        w_publicar = (r_estado == CONCLUIR) && !aa_atualizar_in;
    end

    // Input snapshot captured on every start request.
    always_ff @(posedge clk) begin
        // NOTE: the snapshot is pure data, always rewritten before use, so it carries no reset.
        if (aa_atualizar_in) begin
            r_snap_ativo    <= na_ativo_in;
            r_snap_criterio <= na_criterio_in;
        end
    end

    // Accumulator and beat counter; the counter holds at the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat         <= '0;
            r_acc_achou    <= 1'b0;
            r_acc_criterio <= '1;
            r_acc_indice   <= '0;
        end else if (aa_atualizar_in) begin
            r_beat         <= '0;
            r_acc_achou    <= 1'b0;
            r_acc_criterio <= '1;
            r_acc_indice   <= '0;
        end else if (r_estado == VARRER) begin
            if (w_arv_valido && (!r_acc_achou || (w_arv_criterio < r_acc_criterio))) begin
                r_acc_achou    <= 1'b1;
                r_acc_criterio <= w_arv_criterio;
                r_acc_indice   <= w_arv_indice;
            end
            if (!w_ultimo_beat) r_beat <= r_beat + 1'b1;
        end
    end

    // Published result registers; change only together with the pronto pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pronto       <= 1'b0;
            r_valido       <= 1'b0;
            r_criterio_out <= '1;
            r_indice_out   <= '0;
        end else begin
            r_pronto <= w_publicar;
            if (w_publicar) begin
                r_valido       <= r_acc_achou;
                r_criterio_out <= r_acc_criterio;
                r_indice_out   <= r_acc_indice;
            end
        end
    end

    assign ca_ocupado_o          = w_ocupado;
    assign ca_pronto_o           = r_pronto;
    assign ca_valido_o           = r_valido;
    assign ca_criterio_geral_out = r_criterio_out;
    assign ca_indice_out         = r_indice_out;

endmodule

// File: tb/tb_seletor_minimo_ativo.sv
// Directed bench for seletor_minimo_ativo: an 8-node/2-lane instance and a
// 5-node/2-lane instance exercising the padded last beat.
module tb_seletor_minimo_ativo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        aa_a = 1'b0;
    logic [7:0]  ativo_a = '0;
    logic [39:0] crit_a = '0;
    logic        ocupado_a, pronto_a, valido_a;
    logic [4:0]  cgeral_a;
    logic [2:0]  indice_a;

    logic        aa_b = 1'b0;
    logic [4:0]  ativo_b = '0;
    logic [24:0] crit_b = '0;
    logic        ocupado_b, pronto_b, valido_b;
    logic [4:0]  cgeral_b;
    logic [2:0]  indice_b;

    int checks = 0;
    int errors = 0;

    seletor_minimo_ativo #(.NUM_NA(8), .CRITERIO_WIDTH(5), .LANES(2)) dut_a (
        .clk(clk), .rst(rst), .aa_atualizar_in(aa_a), .na_ativo_in(ativo_a),
        .na_criterio_in(crit_a), .ca_ocupado_o(ocupado_a), .ca_pronto_o(pronto_a),
        .ca_valido_o(valido_a), .ca_criterio_geral_out(cgeral_a), .ca_indice_out(indice_a)
    );

    seletor_minimo_ativo #(.NUM_NA(5), .CRITERIO_WIDTH(5), .LANES(2)) dut_b (
        .clk(clk), .rst(rst), .aa_atualizar_in(aa_b), .na_ativo_in(ativo_b),
        .na_criterio_in(crit_b), .ca_ocupado_o(ocupado_b), .ca_pronto_o(pronto_b),
        .ca_valido_o(valido_b), .ca_criterio_geral_out(cgeral_b), .ca_indice_out(indice_b)
    );

    // Pulse the start request so that it is sampled at edge T; returns at T+1ns.
    task automatic start_a;
        @(negedge clk); aa_a = 1'b1;
        @(posedge clk); #1; aa_a = 1'b0;
    endtask

    task automatic start_b;
        @(negedge clk); aa_b = 1'b1;
        @(posedge clk); #1; aa_b = 1'b0;
    endtask

    // Run n edges, reporting the first edge (1-based) with pronto high and the pulse count.
    task automatic run_a(input int n, output int first, output int cnt);
        first = -1; cnt = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (pronto_a) begin cnt++; if (first < 0) first = k; end
        end
    endtask

    task automatic run_b(input int n, output int first, output int cnt);
        first = -1; cnt = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (pronto_b) begin cnt++; if (first < 0) first = k; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        checks++; if (ocupado_a !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %0d want 0", ocupado_a); end
        checks++; if (pronto_a !== 1'b0) begin errors++; $display("FAIL reset_pronto got %0d want 0", pronto_a); end
        checks++; if (valido_a !== 1'b0) begin errors++; $display("FAIL reset_valido got %0d want 0", valido_a); end
        checks++; if (cgeral_a !== 5'd31) begin errors++; $display("FAIL reset_criterio got %0d want 31", cgeral_a); end
        checks++; if (indice_a !== 3'd0) begin errors++; $display("FAIL reset_indice got %0d want 0", indice_a); end
        @(negedge clk); rst = 1'b0;
    endtask

    // All active {9,3,7,3,12,20,5,8}: min 3, tie between nodes 1 and 3 -> 1.
    task automatic test_basic;
        ativo_a = 8'hFF;
        crit_a  = {5'd8, 5'd5, 5'd20, 5'd12, 5'd3, 5'd7, 5'd3, 5'd9};
        start_a;
        checks++; if (ocupado_a !== 1'b1) begin errors++; $display("FAIL basic_ocupado_T got %0d want 1", ocupado_a); end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                checks++; if (ocupado_a !== 1'b1) begin errors++; $display("FAIL basic_ocupado_T3 got %0d want 1", ocupado_a); end
            end
            if (k == 4) begin
                checks++; if (ocupado_a !== 1'b0) begin errors++; $display("FAIL basic_ocupado_T4 got %0d want 0", ocupado_a); end
                checks++; if (pronto_a !== 1'b0) begin errors++; $display("FAIL basic_pronto_T4 got %0d want 0", pronto_a); end
            end
            if (k == 5) begin
                checks++; if (pronto_a !== 1'b1) begin errors++; $display("FAIL basic_pronto_T5 got %0d want 1", pronto_a); end
                checks++; if (cgeral_a !== 5'd3) begin errors++; $display("FAIL basic_criterio got %0d want 3", cgeral_a); end
                checks++; if (indice_a !== 3'd1) begin errors++; $display("FAIL basic_indice got %0d want 1", indice_a); end
                checks++; if (valido_a !== 1'b1) begin errors++; $display("FAIL basic_valido got %0d want 1", valido_a); end
            end
            if (k == 6) begin
                checks++; if (pronto_a !== 1'b0) begin errors++; $display("FAIL basic_pronto_T6 got %0d want 0", pronto_a); end
                checks++; if (cgeral_a !== 5'd3) begin errors++; $display("FAIL basic_hold got %0d want 3", cgeral_a); end
            end
        end
    endtask

    // No active node; previous result must stay visible until the new pronto.
    task automatic test_none;
        int first, cnt;
        ativo_a = 8'h00;
        start_a;
        run_a(2, first, cnt);
        checks++; if (cgeral_a !== 5'd3) begin errors++; $display("FAIL none_hold_criterio got %0d want 3", cgeral_a); end
        checks++; if (indice_a !== 3'd1) begin errors++; $display("FAIL none_hold_indice got %0d want 1", indice_a); end
        run_a(6, first, cnt);
        checks++; if (first !== 3) begin errors++; $display("FAIL none_pronto_cycle got %0d want 3", first); end
        checks++; if (valido_a !== 1'b0) begin errors++; $display("FAIL none_valido got %0d want 0", valido_a); end
        checks++; if (cgeral_a !== 5'd31) begin errors++; $display("FAIL none_criterio got %0d want 31", cgeral_a); end
        checks++; if (indice_a !== 3'd0) begin errors++; $display("FAIL none_indice got %0d want 0", indice_a); end
    endtask

    // Only node 6 active, criterion all-ones; inactive nodes carry 0.
    task automatic test_all_ones;
        int first, cnt;
        ativo_a = 8'h40;
        crit_a  = '0;
        crit_a[30 +: 5] = 5'd31;
        start_a;
        run_a(8, first, cnt);
        checks++; if (first !== 5) begin errors++; $display("FAIL ones_pronto_cycle got %0d want 5", first); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL ones_pronto_count got %0d want 1", cnt); end
        checks++; if (valido_a !== 1'b1) begin errors++; $display("FAIL ones_valido got %0d want 1", valido_a); end
        checks++; if (cgeral_a !== 5'd31) begin errors++; $display("FAIL ones_criterio got %0d want 31", cgeral_a); end
        checks++; if (indice_a !== 3'd6) begin errors++; $display("FAIL ones_indice got %0d want 6", indice_a); end
    endtask

    // Inputs change mid-scan; the snapshot result must be unaffected.
    task automatic test_snapshot;
        int first, cnt;
        ativo_a = 8'hFF;
        crit_a  = {5'd8, 5'd5, 5'd20, 5'd12, 5'd3, 5'd7, 5'd3, 5'd9};
        start_a;
        run_a(2, first, cnt);
        crit_a[35 +: 5] = 5'd0;
        run_a(6, first, cnt);
        checks++; if (first !== 3) begin errors++; $display("FAIL snap_pronto_cycle got %0d want 3", first); end
        checks++; if (cgeral_a !== 5'd3) begin errors++; $display("FAIL snap_criterio got %0d want 3", cgeral_a); end
        checks++; if (indice_a !== 3'd1) begin errors++; $display("FAIL snap_indice got %0d want 1", indice_a); end
    endtask

    // Start at T, change node 7 to 0 and restart at T+3: single pronto at T+8.
    task automatic test_restart;
        int first, cnt;
        int early;
        early = 0;
        crit_a = {5'd8, 5'd5, 5'd20, 5'd12, 5'd3, 5'd7, 5'd3, 5'd9};
        start_a;
        @(posedge clk); #1; if (pronto_a) early++;
        @(posedge clk); #1; if (pronto_a) early++;
        crit_a[35 +: 5] = 5'd0;
        aa_a = 1'b1;
        @(posedge clk); #1; if (pronto_a) early++;
        aa_a = 1'b0;
        run_a(9, first, cnt);
        checks++; if (early !== 0) begin errors++; $display("FAIL restart_early_pronto got %0d want 0", early); end
        checks++; if (first !== 5) begin errors++; $display("FAIL restart_pronto_cycle got %0d want 5", first); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL restart_pronto_count got %0d want 1", cnt); end
        checks++; if (cgeral_a !== 5'd0) begin errors++; $display("FAIL restart_criterio got %0d want 0", cgeral_a); end
        checks++; if (indice_a !== 3'd7) begin errors++; $display("FAIL restart_indice got %0d want 7", indice_a); end
    endtask

    // Restart during CONCLUIR suppresses that pronto; cross-beat tie 5 vs 7 -> 5.
    task automatic test_back_to_back;
        int first, cnt;
        crit_a = {5'd8, 5'd5, 5'd20, 5'd12, 5'd3, 5'd7, 5'd3, 5'd9};
        start_a;
        run_a(3, first, cnt);
        @(posedge clk); #1;
        crit_a = {5'd2, 5'd16, 5'd2, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10};
        aa_a = 1'b1;
        @(posedge clk); #1;
        aa_a = 1'b0;
        checks++; if (pronto_a !== 1'b0) begin errors++; $display("FAIL b2b_suppressed got %0d want 0", pronto_a); end
        checks++; if (cgeral_a !== 5'd0) begin errors++; $display("FAIL b2b_hold got %0d want 0", cgeral_a); end
        run_a(8, first, cnt);
        checks++; if (first !== 5) begin errors++; $display("FAIL b2b_pronto_cycle got %0d want 5", first); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL b2b_pronto_count got %0d want 1", cnt); end
        checks++; if (cgeral_a !== 5'd2) begin errors++; $display("FAIL b2b_criterio got %0d want 2", cgeral_a); end
        checks++; if (indice_a !== 3'd5) begin errors++; $display("FAIL b2b_indice got %0d want 5", indice_a); end
    endtask

    // Reset asserted at T+2 clears outputs at once; no pronto afterwards.
    task automatic test_reset_mid;
        int first, cnt;
        start_a;
        run_a(2, first, cnt);
        rst = 1'b1;
        #1;
        checks++; if (ocupado_a !== 1'b0) begin errors++; $display("FAIL rmid_ocupado got %0d want 0", ocupado_a); end
        checks++; if (pronto_a !== 1'b0) begin errors++; $display("FAIL rmid_pronto got %0d want 0", pronto_a); end
        checks++; if (valido_a !== 1'b0) begin errors++; $display("FAIL rmid_valido got %0d want 0", valido_a); end
        checks++; if (cgeral_a !== 5'd31) begin errors++; $display("FAIL rmid_criterio got %0d want 31", cgeral_a); end
        checks++; if (indice_a !== 3'd0) begin errors++; $display("FAIL rmid_indice got %0d want 0", indice_a); end
        @(negedge clk); rst = 1'b0;
        run_a(10, first, cnt);
        checks++; if (cnt !== 0) begin errors++; $display("FAIL rmid_no_pronto got %0d want 0", cnt); end
    endtask

    // Five nodes, padded last beat: B=3, pronto at T+4.
    task automatic test_five_nodes;
        int first, cnt;
        ativo_b = 5'h1F;
        crit_b  = {5'd1, 5'd3, 5'd7, 5'd3, 5'd9};
        start_b;
        run_b(8, first, cnt);
        checks++; if (first !== 4) begin errors++; $display("FAIL five_pronto_cycle got %0d want 4", first); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL five_pronto_count got %0d want 1", cnt); end
        checks++; if (cgeral_b !== 5'd1) begin errors++; $display("FAIL five_criterio got %0d want 1", cgeral_b); end
        checks++; if (indice_b !== 3'd4) begin errors++; $display("FAIL five_indice got %0d want 4", indice_b); end
        checks++; if (valido_b !== 1'b1) begin errors++; $display("FAIL five_valido got %0d want 1", valido_b); end
        // Nothing active: the padding lane must not produce a result.
        ativo_b = 5'h00;
        start_b;
        run_b(6, first, cnt);
        checks++; if (first !== 4) begin errors++; $display("FAIL five_none_cycle got %0d want 4", first); end
        checks++; if (valido_b !== 1'b0) begin errors++; $display("FAIL five_none_valido got %0d want 0", valido_b); end
        checks++; if (indice_b !== 3'd0) begin errors++; $display("FAIL five_none_indice got %0d want 0", indice_b); end
        // Within-beat tie between nodes 0 and 1 -> 0.
        ativo_b = 5'h1F;
        crit_b  = {5'd9, 5'd9, 5'd9, 5'd6, 5'd6};
        start_b;
        run_b(6, first, cnt);
        checks++; if (cgeral_b !== 5'd6) begin errors++; $display("FAIL five_tie_criterio got %0d want 6", cgeral_b); end
        checks++; if (indice_b !== 3'd0) begin errors++; $display("FAIL five_tie_indice got %0d want 0", indice_b); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_none;
        test_all_ones;
        test_snapshot;
        test_restart;
        test_back_to_back;
        test_reset_mid;
        test_five_nodes;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seletor_minimo_ativo.md
SELETOR_MINIMO_ATIVO -- requirements
Module: seletor_minimo_ativo

Interface
REQ-001 SHALL have parameter NUM_NA, default 8: number of nodes scanned (>=2).
REQ-002 SHALL have parameter CRITERIO_WIDTH, default 5: criterion width per node.
REQ-003 SHALL have parameter LANES, default 2: nodes compared per scan cycle (1..NUM_NA); need not divide NUM_NA.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port aa_atualizar_in  input  1  start/restart request, single-cycle pulse.
REQ-007 SHALL have port na_ativo_in  input  NUM_NA  per-node active flag.
REQ-008 SHALL have port na_criterio_in  input  NUM_NA*CRITERIO_WIDTH  packed criteria; node i at bits [CRITERIO_WIDTH*i +: CRITERIO_WIDTH].
REQ-009 SHALL have port ca_ocupado_o  output  1  scan in progress.
REQ-010 SHALL have port ca_pronto_o  output  1  one-cycle result-ready pulse.
REQ-011 SHALL have port ca_valido_o  output  1  at least one active node in the snapshot.
REQ-012 SHALL have port ca_criterio_geral_out  output  CRITERIO_WIDTH  minimum criterion among active nodes.
REQ-013 SHALL have port ca_indice_out  output  clog2(NUM_NA)  index of that node.

Function
REQ-014 SHALL implement FSM OCIOSO -> VARRER -> CONCLUIR -> OCIOSO; B = ceil(NUM_NA/LANES) scan beats.
REQ-015 On aa_atualizar_in high at edge T, SHALL snapshot na_ativo_in and na_criterio_in, clear accumulator (criterion all-ones, index 0, found 0) and enter VARRER; later input changes SHALL NOT affect the result.
REQ-016 In VARRER beat k (0..B-1), SHALL compare snapshot nodes k*LANES..k*LANES+LANES-1 against the accumulator; lanes beyond NUM_NA-1 SHALL be treated as inactive.
REQ-017 Only active nodes SHALL update the accumulator; strict less-than across beats; within a beat, ties SHALL resolve to the lowest index, so overall ties resolve to the lowest index.
REQ-018 An active node with criterion all-ones SHALL be selectable (sets found=1) when no smaller active criterion exists.
REQ-019 After the last beat, SHALL enter CONCLUIR for one cycle and pulse ca_pronto_o; pronto first high at edge T+B+1.
REQ-020 ca_criterio_geral_out, ca_indice_out, ca_valido_o SHALL update only with the pronto pulse and hold until the next pronto; no intermediate accumulator values visible.
REQ-021 ca_ocupado_o SHALL be high from edge T through the edge that raises ca_pronto_o, exclusive of that cycle (high in VARRER only).
REQ-022 aa_atualizar_in during VARRER or CONCLUIR SHALL abort the scan, suppress that pronto, re-snapshot and restart at beat 0.
REQ-023 No active nodes SHALL give ca_valido_o=0, criterion all-ones, index 0.
REQ-024 Beat counter SHALL be clog2(B) wide minimum and SHALL NOT wrap past B-1.

Reset
REQ-025 rst high SHALL immediately force OCIOSO, ca_ocupado_o=0, ca_pronto_o=0, ca_valido_o=0, ca_criterio_geral_out=all-ones, ca_indice_out=0, beat counter 0.
REQ-026 Reset mid-scan SHALL discard the scan; no pronto SHALL follow deassertion without a new aa_atualizar_in.

Structure
REQ-027 Shared package SHALL hold FSM state encoding and width helpers (index width, beat count B, beat-counter width).
REQ-028 Combinational LANES-input min/argmin tree with active masking and lowest-index tie-break SHALL be sub-module arvore_minimo; top holds snapshot, FSM, accumulator.

Verification (NUM_NA=8, LANES=2, CRITERIO_WIDTH=5 unless stated)
REQ-029 All active, criteria {9,3,7,3,12,20,5,8}, start at T -> pronto at T+5, criterio=3, indice=1, valido=1.
REQ-030 na_ativo_in=0 -> pronto at T+5, valido=0, criterio=31, indice=0; only node 6 active with 31 -> valido=1, criterio=31, indice=6.
REQ-031 Start, then at T+2 change node 7 to active criterion 0 -> result unaffected (snapshot); second start at T+3 -> single pronto at T+8 reflecting new inputs, criterio=0, indice=7.
REQ-032 rst asserted at T+2 -> outputs at reset values same cycle; no pronto within 10 cycles after release.
REQ-033 NUM_NA=5, LANES=2, node 4 sole minimum 1 -> B=3, pronto at T+4, indice=4; padding lane never selected.
